// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter
//   Arbitrates num_req push requesters onto the write side of a FIFO of
//   depth D = 2**address_width and tracks FIFO occupancy, throttling pushes
//   at Full and pops at Empty.
//
// Parameters
//   word_length    width of each data word
//   address_width  FIFO address width (depth = 2**address_width)
//   num_req        number of push requesters (2..8)
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   Req       per-requester push request (level)
//   DataReq   flattened request data, requester i at [i*word_length +: word_length]
//   PopReq    consumer pop request (level)
//   Grant     registered one-hot push acknowledge
//   Push      registered push strobe to the FIFO
//   FifoData  registered data to the FIFO DataIn
//   Pop       registered pop strobe to the FIFO
//   Count     occupancy, including the operations currently on Push/Pop
//   Full      Count == depth
//   Empty     Count == 0
//
// Configuration
//   FIFO_ARB_FIXED_PRIO_EN  when defined, fixed priority (lowest index wins);
//                           otherwise round-robin starting after the last grant.

module fifo_push_arbiter #(
  parameter int unsigned word_length   = 8,
  parameter int unsigned address_width = 4,
  parameter int unsigned num_req       = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [num_req-1:0]             Req,
  input  logic [num_req*word_length-1:0] DataReq,
  input  logic                           PopReq,
  output logic [num_req-1:0]             Grant,
  output logic                           Push,
  output logic [word_length-1:0]         FifoData,
  output logic                           Pop,
  output logic [address_width:0]         Count,
  output logic                           Full,
  output logic                           Empty
);

  localparam int unsigned IW    = (num_req > 1) ? $clog2(num_req) : 1;
  localparam int unsigned DEPTH = 2 ** address_width;
  localparam logic [address_width:0] DEPTH_C = DEPTH[address_width:0];

  logic [num_req-1:0]     r_grant;
  logic                   r_push;
  logic [word_length-1:0] r_data;
  logic                   r_pop;
  logic [address_width:0] r_count;

  logic [num_req-1:0]     w_eff;
  logic                   w_found;
  logic [IW-1:0]          w_win;
  logic                   w_push_next;
  logic                   w_pop_next;
  logic [num_req-1:0]     w_onehot;
  logic [word_length-1:0] w_win_data;

  // Masking with the current Grant keeps a requester that is being
  // acknowledged this cycle (and has not yet dropped Req) from winning again.
  assign w_eff = Req & ~r_grant;

`ifdef FIFO_ARB_FIXED_PRIO_EN

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned k = 0; k < num_req; k++) begin
      if (!w_found && w_eff[k]) begin
        w_found = 1'b1;
        w_win   = IW'(k);
      end
    end
  end

`else

  logic [IW-1:0] r_last;
  int unsigned   w_idx;

  // Search begins one past the most recent winner and wraps.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int unsigned k = 1; k <= num_req; k++) begin
      w_idx = (32'(r_last) + k) % num_req;
      if (!w_found && w_eff[w_idx]) begin
        w_found = 1'b1;
        w_win   = IW'(w_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= IW'(num_req - 1);
    end else if (w_push_next) begin
      r_last <= w_win;
    end
  end

`endif

  assign w_push_next = w_found && (r_count < DEPTH_C);
  assign w_pop_next  = PopReq && (r_count != '0);
  assign w_onehot    = num_req'(1) << w_win;
  assign w_win_data  = DataReq[32'(w_win)*word_length +: word_length];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant <= '0;
      r_push  <= 1'b0;
      r_data  <= '0;
      r_pop   <= 1'b0;
      r_count <= '0;
    end else begin
      r_pop <= w_pop_next;
      if (w_push_next) begin
        r_grant <= w_onehot;
        r_push  <= 1'b1;
        r_data  <= w_win_data;
      end else begin
        r_grant <= '0;
        r_push  <= 1'b0;
      end
      unique case ({w_push_next, w_pop_next})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign Grant    = r_grant;
  assign Push     = r_push;
  assign FifoData = r_data;
  assign Pop      = r_pop;
  assign Count    = r_count;
  assign Full     = (r_count == DEPTH_C);
  assign Empty    = (r_count == '0);

endmodule
